// File: rtl/wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wash_sequencer
// Brief    : Steps a latched 26-bit washing program through eight timed phases
//            on a one-second tick and drives the fill/agitate/drain/spin enables.
// Revision : 1.0 - initial release
// ============================================================================
module wash_sequencer #(
  parameter int TOTAL_W = 7
) (
  input  logic               cp,
  input  logic               rst,
  input  logic               secTick,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [25:0]        program_word,
  output logic [2:0]         phase,
  output logic [3:0]         remain,
  output logic [TOTAL_W-1:0] totalRemain,
  output logic               busy,
  output logic               done,
  output logic               waterIn,
  output logic               motor,
  output logic               drainOut,
  output logic               spin
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSE  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  function automatic logic [3:0] field_of(input logic [25:0] p, input logic [2:0] idx);
    logic [3:0] f;
    case (idx)
      3'd0:    f = {1'b0, p[25:23]};
      3'd1:    f = p[22:19];
      3'd2:    f = {1'b0, p[18:16]};
      3'd3:    f = {1'b0, p[15:13]};
      3'd4:    f = {1'b0, p[12:10]};
      3'd5:    f = p[9:6];
      3'd6:    f = {1'b0, p[5:3]};
      default: f = {1'b0, p[2:0]};
    endcase
    return f;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [25:0]        prog_q, prog_d;
  logic [2:0]         phase_q, phase_d;
  logic [3:0]         remain_q, remain_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               water_q, water_d, motor_q, motor_d;
  logic               drain_q, drain_d, spin_q, spin_d;

  logic               first_found, next_found;
  logic [2:0]         first_idx, next_idx;
  logic [TOTAL_W-1:0] prog_sum;

  // Descending scan leaves the lowest qualifying index; zero fields never qualify.
  always_comb begin
    first_found = 1'b0;
    first_idx   = 3'd0;
    next_found  = 1'b0;
    next_idx    = 3'd0;
    prog_sum    = '0;
    for (int i = 7; i >= 0; i--) begin
      if (field_of(program_word, 3'(i)) != 4'd0) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
      if ((3'(i) > phase_q) && (field_of(prog_q, 3'(i)) != 4'd0)) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
      prog_sum = prog_sum + TOTAL_W'(field_of(program_word, 3'(i)));
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prog_q   <= '0;
      phase_q  <= '0;
      remain_q <= '0;
      total_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      water_q  <= 1'b0;
      motor_q  <= 1'b0;
      drain_q  <= 1'b0;
      spin_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prog_q   <= prog_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      total_q  <= total_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      water_q  <= water_d;
      motor_q  <= motor_d;
      drain_q  <= drain_d;
      spin_q   <= spin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    total_d  = total_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (first_found) begin
            state_d  = S_RUN;
            prog_d   = program_word;
            phase_d  = first_idx;
            remain_d = field_of(program_word, first_idx);
            total_d  = prog_sum;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_IDLE;
          prog_d   = '0;
          phase_d  = '0;
          remain_d = '0;
          total_d  = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (secTick) begin
          total_d = total_q - TOTAL_W'(1);
          if (remain_q > 4'd1) begin
            remain_d = remain_q - 4'd1;
          end else if (next_found) begin
            phase_d  = next_idx;
            remain_d = field_of(prog_q, next_idx);
          end else begin
            state_d  = S_FINISH;
            prog_d   = '0;
            phase_d  = '0;
            remain_d = '0;
            total_d  = '0;
          end
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_d  = S_IDLE;
          prog_d   = '0;
          phase_d  = '0;
          remain_d = '0;
          total_d  = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d  = S_IDLE;
        prog_d   = '0;
        phase_d  = '0;
        remain_d = '0;
        total_d  = '0;
      end
    endcase
  end

  // Actuators follow phase modulo 4: fill, agitate, drain, spin.
  always_comb begin
    busy_d  = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d  = (state_d == S_FINISH);
    water_d = 1'b0;
    motor_d = 1'b0;
    drain_d = 1'b0;
    spin_d  = 1'b0;
    if (state_d == S_RUN) begin
      case (phase_d[1:0])
        2'd0:    water_d = 1'b1;
        2'd1:    motor_d = 1'b1;
        2'd2:    drain_d = 1'b1;
        default: begin
          drain_d = 1'b1;
          spin_d  = 1'b1;
        end
      endcase
    end
  end

  assign phase       = phase_q;
  assign remain      = remain_q;
  assign totalRemain = total_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign waterIn     = water_q;
  assign motor       = motor_q;
  assign drainOut    = drain_q;
  assign spin        = spin_q;

endmodule
`default_nettype wire

// File: tb/tb_wash_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_sequencer
// Brief    : Directed and random stimulus for wash_sequencer, checked against an
//            elapsed-time reference model of the program.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_sequencer;
  localparam int TOTAL_W = 7;
  localparam logic [25:0] DEF_PROG   = 26'b011_1010_100_101_011_1000_100_101;
  localparam logic [25:0] RINSE_PROG = 26'b000_0000_100_101_011_1000_100_101;
  localparam logic [25:0] WASH_PROG  = 26'b011_1010_000_000_000_0000_000_000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FIN = 3;

  logic cp = 1'b0;
  logic rst, sec_tick, start, pause, abort;
  logic [25:0] prog_w;
  logic [2:0] phase;
  logic [3:0] remain;
  logic [TOTAL_W-1:0] total_remain;
  logic busy, done, water_in, motor, drain_out, spin;

  wash_sequencer #(.TOTAL_W(TOTAL_W)) dut (
    .cp(cp), .rst(rst), .secTick(sec_tick), .start(start), .pause(pause),
    .abort(abort), .program_word(prog_w), .phase(phase), .remain(remain),
    .totalRemain(total_remain), .busy(busy), .done(done), .waterIn(water_in),
    .motor(motor), .drainOut(drain_out), .spin(spin)
  );

  always #5 cp = ~cp;

  int n_assert = 0;
  int n_fail   = 0;
  int m_mode   = M_IDLE;
  int m_f[8];
  int m_tot    = 0;
  int m_t      = 0;
  int fw[8]    = '{3, 4, 3, 3, 3, 4, 3, 3};

  function automatic int field_val(logic [25:0] p, int idx);
    int pos = 26;
    for (int j = 0; j <= idx; j++) pos -= fw[j];
    return int'((p >> pos) & ((26'd1 << fw[idx]) - 26'd1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: program reduced to its field list plus ticks elapsed in RUN.
  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (start && !abort) begin
          m_tot = 0;
          for (int i = 0; i < 8; i++) begin
            m_f[i] = field_val(prog_w, i);
            m_tot += m_f[i];
          end
          m_t = 0;
          m_mode = (m_tot == 0) ? M_FIN : M_RUN;
        end
        M_RUN: begin
          if (abort) m_mode = M_IDLE;
          else if (pause) m_mode = M_PAUSE;
          else if (sec_tick) begin
            m_t++;
            if (m_t == m_tot) m_mode = M_FIN;
          end
        end
        M_PAUSE: begin
          if (abort) m_mode = M_IDLE;
          else if (!pause) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check_all();
    int e_ph = 0, e_rem = 0, e_tot = 0, acc = 0, k;
    logic active;
    active = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    if (active) begin
      for (int i = 7; i >= 0; i--) begin
        acc = 0;
        for (int j = 0; j <= i; j++) acc += m_f[j];
        if (m_t < acc && m_f[i] != 0) begin
          e_ph  = i;
          e_rem = acc - m_t;
        end
      end
      e_tot = m_tot - m_t;
    end
    k = e_ph % 4;
    chk("busy", busy, active);
    chk("done", done, m_mode == M_FIN);
    chk("phase", phase, e_ph);
    chk("remain", remain, e_rem);
    chk("totalRemain", total_remain, e_tot);
    chk("waterIn", water_in, (m_mode == M_RUN) && k == 0);
    chk("motor", motor, (m_mode == M_RUN) && k == 1);
    chk("drainOut", drain_out, (m_mode == M_RUN) && k >= 2);
    chk("spin", spin, (m_mode == M_RUN) && k == 3);
  endtask

  task automatic cycle();
    @(posedge cp);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    sec_tick = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    sec_tick = 1'b0;
  endtask

  task automatic launch(input logic [25:0] p);
    prog_w = p;
    start  = 1'b1;
    cycle();
    start  = 1'b0;
  endtask

  initial begin
    int done_cnt, low_phase;
    logic seen;
    rst = 1'b1; sec_tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    prog_w = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Full default program, with a start/program change while busy.
    launch(DEF_PROG);
    chk("def_total", total_remain, 42);
    chk("def_remain", remain, 3);
    done_cnt = 0;
    sec_tick = 1'b1;
    for (int i = 0; i < 42; i++) begin
      if (i == 10) begin start = 1'b1; prog_w = WASH_PROG; end
      if (i == 11) start = 1'b0;
      cycle();
      if (done) done_cnt++;
    end
    sec_tick = 1'b0;
    chk("def_done_at_end", done, 1);
    cycle();
    chk("def_done_count", done_cnt, 1);
    chk("def_idle_busy", busy, 0);

    // Rinse/dry-only program.
    launch(RINSE_PROG);
    chk("rinse_phase", phase, 2);
    chk("rinse_remain", remain, 4);
    chk("rinse_total", total_remain, 29);
    chk("rinse_drain", drain_out, 1);
    seen = 1'b0;
    low_phase = 7;
    sec_tick = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      if (busy && phase < low_phase) low_phase = phase;
      if (done) seen = 1'b1;
    end
    sec_tick = 1'b0;
    chk("rinse_done_seen", seen, 1);
    chk("rinse_min_phase", low_phase, 2);
    cycle();

    // Pause at phase 1 remain 7, with a coincident tick and ticks while paused.
    launch(DEF_PROG);
    ticks(6);
    chk("pre_pause_remain", remain, 7);
    pause = 1'b1;
    sec_tick = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("pause_motor", motor, 0);
    chk("pause_remain", remain, 7);
    chk("pause_total", total_remain, 36);
    pause = 1'b0;
    sec_tick = 1'b0;
    cycle();
    chk("resume_motor", motor, 1);
    ticks(1);
    chk("resume_remain", remain, 6);

    // Abort during phase 5, then a wash-only program.
    ticks(20);
    chk("abort_pre_phase", phase, 5);
    abort = 1'b1;
    sec_tick = 1'b1;
    cycle();
    abort = 1'b0;
    sec_tick = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    launch(WASH_PROG);
    chk("wash_phase", phase, 0);
    chk("wash_total", total_remain, 13);
    ticks(13);
    chk("wash_done", done, 1);
    cycle();

    // Empty program.
    launch(26'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    cycle();
    chk("zero_done_clear", done, 0);

    // Reset during phase 3 with a coincident tick.
    launch(DEF_PROG);
    ticks(18);
    chk("rst_pre_phase", phase, 3);
    rst = 1'b1;
    sec_tick = 1'b1;
    cycle();
    rst = 1'b0;
    sec_tick = 1'b0;
    chk("rst_total", total_remain, 0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      sec_tick = ($urandom_range(1, 0) == 1);
      pause    = ($urandom_range(9, 0) == 0) ? ~pause : pause;
      abort    = ($urandom_range(59, 0) == 0);
      start    = ($urandom_range(7, 0) == 0);
      rst      = ($urandom_range(499, 0) == 0);
      prog_w   = 26'($urandom);
      if ($urandom_range(3, 0) == 0) prog_w = prog_w & 26'($urandom);
      if ($urandom_range(3, 0) == 0) prog_w = prog_w & 26'($urandom);
      if ($urandom_range(40, 0) == 0) prog_w = '0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Downstream consumer of the 26-bit program word produced by the washing-machine program/settings model.
- Latches the program on start, then steps through eight timed phases: wash fill/agitate/drain/spin, then rinse fill/agitate/drain/spin.
- Counts each phase down on an external one-second tick and drives the actuator enables.
- Reports current phase, phase time remaining and total time remaining to the display path.

Parameters:
TOTAL_W, 7, width of the total-remaining counter; the maximum program total is 72 ticks, so the width must be at least 7.

Ports:
cp  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
secTick  input  1  one-cycle pulse per second (time base)
start  input  1  begin program; sampled only in IDLE
pause  input  1  level; hold sequence while high
abort  input  1  pulse; cancel program, return to IDLE
program  input  26  {wFill[3], wWash[4], wDrain[3], wSpin[3], rFill[3], rRinse[4], rDrain[3], rSpin[3]}, MSB first, durations in ticks
phase  output  3  0..7 = wFill, wWash, wDrain, wSpin, rFill, rRinse, rDrain, rSpin
remain  output  4  ticks left in current phase
totalRemain  output  TOTAL_W  ticks left in whole program
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse at program completion
waterIn  output  1  fill valve
motor  output  1  drum agitate
drainOut  output  1  drain pump
spin  output  1  spin motor

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE. All outputs go to 0. The latched program is cleared. This applies in any state, including mid-program.
- States: IDLE, RUN, PAUSE, FINISH (one cycle).
- IDLE, start=1, program!=0:
  - latch program.
  - phase <= index of the first nonzero field.
  - remain <= that field.
  - totalRemain <= sum of all eight fields, zero-extended.
  - enter RUN next cycle.
- IDLE, start=1, program==0: go to FINISH (done pulses); no actuator activity.
- start outside IDLE is ignored; a program change while busy has no effect.
- RUN, secTick=1, pause=0:
  - totalRemain decrements by 1.
  - If remain>1: remain decrements by 1.
  - If remain==1: advance to the next phase index with a nonzero field, load remain from it. If none remain, go to FINISH with remain=0 and totalRemain=0.
  - Zero-length phases are skipped in the same cycle; phase never dwells on a zero field.
- RUN, pause=1: enter PAUSE next cycle. A secTick in the same cycle is dropped (pause wins). Counters are frozen.
- PAUSE, pause=0: return to RUN next cycle. Ticks during PAUSE are ignored.
- abort=1 in RUN/PAUSE/FINISH: IDLE next cycle, all outputs 0, no done pulse. abort beats start, pause and secTick in the same cycle.
- FINISH: done=1 for exactly this cycle, busy=0, actuators 0, phase=0. Always IDLE next cycle.
- Actuators are registered and valid only in RUN:
  - fill phases (0, 4): waterIn=1
  - wash/rinse phases (1, 5): motor=1
  - drain phases (2, 6): drainOut=1
  - spin phases (3, 7): drainOut=1, spin=1
- In PAUSE, IDLE and FINISH all actuators are 0; phase/remain/totalRemain hold in PAUSE.
- Latency: start to busy=1 and actuators valid is one cycle. secTick to counter update is one cycle.
- Invariant in RUN/PAUSE: totalRemain = remain + sum of later nonzero fields.

Test Plan:
- Full default program 26'b011_1010_100_101_011_1000_100_101, start, 42 ticks -> totalRemain 42 counting to 0; phases 0..7 with remain 3,10,4,5,3,8,4,5; done single pulse after tick 42; then IDLE.
- Rinse/dry-only program 26'b000_0000_100_101_011_1000_100_101 -> first phase=2, remain=4, totalRemain=29; drainOut=1; phases 0/1 never appear.
- Pause at phase 1 with remain=7, 5 ticks during pause, pause with secTick in the same cycle -> motor=0, remain stays 7, totalRemain unchanged; resume to RUN, motor=1, next tick gives remain=6.
- abort mid-phase 5 -> IDLE next cycle, busy=0, all actuators 0, no done. Then start with 26'b011_1010_0...0 -> phase 0, totalRemain=13.
- program=0 with start -> done pulses one cycle, busy stays 0. start while busy -> ignored, counters undisturbed.
- rst asserted during RUN phase 3 -> next cycle all outputs 0, IDLE. A secTick coinciding with rst has no effect.
